// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one iterative multiplier between two
// requesters, latching operands, capturing HI/LO and aborting hung operations.
module mult_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] x1,
    input  logic [31:0] y1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        err,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_start,
    input  logic        mul_busy,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo
);
    typedef enum logic [1:0] { IDLE, LAUNCH, RUN, DONE } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            owner;     // requester currently being served
    logic            prio;      // requester that wins when both ask at once
    logic [WD_W-1:0] wdog;

    logic grant_any;
    logic grant_id;
    logic finished;
    logic expired;

    assign grant_any = req0 | req1;
    assign grant_id  = (req0 && req1) ? prio : req1;
    assign finished  = (state == RUN) && !mul_busy;
    assign expired   = (wdog == WD_LAST);

    // NOTE: every state bit and output is a flop updated with <=, so all
    // branches below read the pre-edge values and outputs never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            prio      <= 1'b0;
            wdog      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
        end else begin
            // NOTE: done pulses default low here so each lasts exactly one cycle.
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_id;
                        mul_x     <= grant_id ? x1 : x0;
                        mul_y     <= grant_id ? y1 : y0;
                        wdog      <= '0;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH, RUN: begin
                    wdog <= wdog + 1'b1;
                    // A result arriving on the watchdog's last cycle is still kept.
                    if (finished || expired) begin
                        state     <= DONE;
                        mul_start <= 1'b0;
                        done0     <= ~owner;
                        done1     <= owner;
                        if (finished) begin
                            hi_out <= mul_hi;
                            lo_out <= mul_lo;
                        end else begin
                            err    <= 1'b1;
                            hi_out <= '0;
                            lo_out <= '0;
                        end
                    end else if (state == LAUNCH && mul_busy) begin
                        state     <= RUN;
                        mul_start <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    prio  <= ~owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed scoreboard bench for mult_arbiter with a behavioural
// iterative multiplier that keeps mul_busy high for B cycles.
module tb_mult_arbiter;
    localparam int B       = 33;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] x0, y0, x1, y1;
    logic        done0, done1;
    logic [31:0] hi_out, lo_out;
    logic        busy, err;
    logic [31:0] mul_x, mul_y;
    logic        mul_start;
    logic        mul_busy;
    logic [31:0] mul_hi, mul_lo;

    mult_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .done0(done0), .done1(done1),
        .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .err(err),
        .mul_x(mul_x), .mul_y(mul_y),
        .mul_start(mul_start), .mul_busy(mul_busy),
        .mul_hi(mul_hi), .mul_lo(mul_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_grants = 0;
    int n_starts = 0;
    logic ms_prev = 1'b0;
    bit   mul_dead = 1'b0;

    typedef struct {
        bit          id;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          err;
        int          at_cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Behavioural multiplier: reads its operands when it finishes, so unstable
    // mul_x/mul_y during the operation corrupt the product.
    int m_cnt;
    always @(posedge clk) begin
        if (reset) begin
            mul_busy <= 1'b0;
            m_cnt    <= 0;
            mul_hi   <= '0;
            mul_lo   <= '0;
        end else if (mul_busy) begin
            if (m_cnt == 0) begin
                mul_busy         <= 1'b0;
                {mul_hi, mul_lo} <= smul(mul_x, mul_y);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mul_start && !mul_dead) begin
            mul_busy <= 1'b1;
            m_cnt    <= B - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters drop their request during their done cycle.
    always @(negedge clk) begin
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
    end

    always @(negedge clk) begin
        if (mul_start && !ms_prev) n_starts++;
        ms_prev = mul_start;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done0 || done1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", {62'b0, done1, done0}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_id", {62'b0, done1, done0}, e.id ? 64'd2 : 64'd1);
                check("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
                check("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
                check("err_at_done", {63'b0, err}, {63'b0, e.err});
                check("done_cycle", 64'(cyc), 64'(e.at_cyc));
            end
        end
    end

    task automatic raise(input bit id, input logic [31:0] x, input logic [31:0] y);
        if (id) begin
            x1 = x; y1 = y; req1 = 1'b1;
        end else begin
            x0 = x; y0 = y; req0 = 1'b1;
        end
        n_grants++;
    endtask

    task automatic push_exp(input bit id, input logic [31:0] hi, input logic [31:0] lo,
                            input bit e_err, input int at_cyc);
        exp_t e;
        e.id = id; e.hi = hi; e.lo = lo; e.err = e_err; e.at_cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((sb_q.size() != 0 || req0 || req1 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({"wait_", tag}, {63'b0, (k < budget)}, 64'd1);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, {62'b0, done1, done0}, 64'd0);
        check({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
        check({tag, "_busy_err"}, {62'b0, busy, err}, 64'd0);
        check({tag, "_mul_xy"}, {mul_x, mul_y}, 64'd0);
        check({tag, "_mul_start"}, {63'b0, mul_start}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int k;
        int bad;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single request: 7 * 6.
        n = cyc;
        raise(1'b0, 32'd7, 32'd6);
        push_exp(1'b0, 32'h0000_0000, 32'h0000_002A, 1'b0, n + B + 3);
        wait_idle("single", 200);
        check("mul_xy_hold", {mul_x, mul_y}, {32'd7, 32'd6});

        // Signed operands: -3 * 5, busy high through the DONE cycle only.
        @(negedge clk);
        n = cyc;
        raise(1'b1, 32'hFFFF_FFFD, 32'd5);
        push_exp(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, n + B + 3);
        bad = 0;
        for (int i = 1; i <= B + 3; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("busy_span", 64'(bad), 64'd0);
        @(negedge clk);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        wait_idle("signed", 200);

        // Contention: req0 wins, then req1, then req0 re-requests.
        n = cyc;
        raise(1'b0, 32'd100, 32'd200);
        raise(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_exp(1'b0, 32'h0, 32'h0000_4E20, 1'b0, n + B + 3);
        push_exp(1'b1, 32'h0, 32'h0000_0001, 1'b0, n + 2 * B + 7);
        k = 0;
        while (req0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("req0_released", {63'b0, (k < 200)}, 64'd1);
        @(negedge clk);
        raise(1'b0, 32'h7FFF_FFFF, 32'd2);
        push_exp(1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0, n + 3 * B + 11);
        wait_idle("contention", 400);

        // Timeout: the multiplier never raises mul_busy.
        mul_dead = 1'b1;
        n = cyc;
        raise(1'b1, 32'd9, 32'd9);
        push_exp(1'b1, 32'h0, 32'h0, 1'b1, n + TIMEOUT + 1);
        wait_idle("timeout", 200);
        mul_dead = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", {63'b0, err}, 64'd1);

        // Operand stability: x0/y0 change illegally during RUN.
        n = cyc;
        raise(1'b0, 32'h0001_0000, 32'h0001_0000);
        push_exp(1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, n + B + 3);
        repeat (5) @(negedge clk);
        x0 = 32'd5;
        y0 = 32'd5;
        @(negedge clk);
        check("mul_xy_stable", {mul_x, mul_y}, {32'h0001_0000, 32'h0001_0000});
        wait_idle("stability", 200);

        // Reset ten cycles into RUN: no done, everything cleared.
        n = cyc;
        raise(1'b0, 32'h0000_CAFE, 32'd3);
        repeat (12) @(negedge clk);
        check("busy_before_reset", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {62'b0, busy, mul_start}, 64'd0);

        // Fresh request after reset, err cleared.
        n = cyc;
        raise(1'b0, 32'h1234_5678, 32'h0000_0010);
        push_exp(1'b0, 32'h0000_0001, 32'h2345_6780, 1'b0, n + B + 3);
        wait_idle("fresh", 200);

        check("mul_start_pulses", 64'(n_starts), 64'(n_grants));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one iterative Booth multiplier between two requesters, e.g. the main control unit and a MULT/MULTU helper path. It latches the winning requester's operands and drives the multiplier's start/busy handshake. It captures the 64-bit HI/LO result and returns it to the owner with a one-cycle done pulse. A watchdog aborts any operation that the multiplier fails to finish.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in LAUNCH+RUN before abort; must be ≥ 40.

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- req0, req1  in  1  level request; held high until the matching done pulse
- x0, y0, x1, y1  in  32  signed operands, stable while req is high
- done0, done1  out  1  one-cycle pulse; hi_out/lo_out valid in the same cycle
- hi_out, lo_out  out  32  registered product of the last completed operation
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag
- mul_x, mul_y  out  32  operands to the multiplier, held for the whole operation
- mul_start  out  1  start level to the multiplier
- mul_busy  in  1  multiplier operating flag
- mul_hi, mul_lo  in  32  multiplier result, valid once mul_busy falls

## Operation
- States: IDLE, LAUNCH, RUN, DONE. Reset forces IDLE.
- Reset values: all outputs 0; round-robin pointer favours req0; watchdog 0; err 0.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not served most recently. After reset, req0 wins.
  - On grant: latch owner, mul_x/mul_y ← owner's x/y, watchdog ← 0, go to LAUNCH.
- LAUNCH: mul_start = 1 (decoded from state). If mul_busy = 1, go to RUN; mul_start is low from the next cycle.
- RUN: mul_start = 0. If mul_busy = 0, then hi_out ← mul_hi, lo_out ← mul_lo, go to DONE.
- Watchdog:
  - Increments every cycle in LAUNCH and RUN.
  - On reaching TIMEOUT_CYCLES: err ← 1, hi_out ← 0, lo_out ← 0, go to DONE.
  - err clears only on reset.
- DONE:
  - Assert done of the owner only, for one cycle.
  - Update the pointer so the other requester has priority next.
  - Return to IDLE.
- Requester rule: the owner drops req at the edge that ends its done cycle. The arbiter never re-grants in DONE.
- A request that arrives while busy waits; it is not lost and not reordered.
- mul_x/mul_y hold their values after completion until the next grant.

## Timing
- Accepting edge E0: IDLE samples req high.
- Let B be the number of cycles mul_busy is high.
- Cycle-by-cycle sequence after E0:
  - Cycle 1: mul_start high.
  - Edge E1: the multiplier raises mul_busy.
  - Edge E2: state moves to RUN.
  - Edge E(B+2): result captured.
  - done is high in cycle B+3.
- Next grant earliest at the edge ending the IDLE cycle after DONE. Back-to-back throughput is one operation per B+4 cycles.
- If mul_busy never rises in LAUNCH, the watchdog fires after TIMEOUT_CYCLES cycles; same if it never falls in RUN.
- Simultaneous events:
  - req rising in the same cycle the other requester's done fires: the new request is serviced next.
  - reset together with anything: reset wins.
- Reset mid-operation: IDLE next cycle, done not emitted, mul_start 0, result discarded. The multiplier shares the same reset.

## Test plan
- Single request: req0, x0=7, y0=6, bench multiplier with B=33 → done0 in cycle 36 after E0; hi_out=0x00000000, lo_out=0x0000002A; done1 stays 0.
- Signed operands: req1, x1=-3, y1=5 → done1 with hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1; busy high from E0 through the DONE cycle.
- Contention: req0 and req1 rise together, then req0 re-requests immediately after its done → order req0, req1, req0; mul_start pulses exactly once per grant.
- Timeout: mul_busy tied 0 with TIMEOUT_CYCLES=64 → after 64 cycles in LAUNCH, done pulse with hi_out=lo_out=0 and err=1; err stays 1 until reset.
- Reset mid-op: reset asserted 10 cycles into RUN → next cycle state IDLE, all outputs 0, no done; a fresh req0 is then serviced normally.
- Operand stability: change x0/y0 during RUN, illegally → mul_x/mul_y unchanged and the product matches the latched values.
